uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Byte-wide UART transmitter, 8N1, LSB first. Pairs with the existing UART receiver on the same serial link. A small input FIFO lets the host queue several bytes. Queued frames go out back-to-back with no idle gap. Sits between the host/command logic and the TX pin.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit (integer, >= 4, <= 65535)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >= 2)

Ports:
i_clock  input  1  system clock, all logic on posedge
i_reset  input  1  synchronous, active-high reset
i_data_valid  input  1  host presents a byte on i_data_byte
i_data_byte  input  8  byte to transmit
o_ready  output  1  FIFO can accept a byte (combinational: FIFO not full)
o_tx  output  1  serial line, registered, idles high
o_busy  output  1  high while a frame is on the line or the FIFO is non-empty
o_done  output  1  one-cycle pulse at the end of each frame's stop bit

Behaviour:
- Reset, sampled on a clock edge: o_tx=1, o_done=0, o_busy=0, o_ready=1; FIFO emptied; state=IDLE; counter=0; bit_index=0.
- Reset mid-frame aborts the frame; o_tx returns high on the next edge. Queued bytes are discarded.
- Push: happens on an edge where i_data_valid && o_ready. If valid is high while full, the byte is dropped silently and FIFO state is unchanged.
- FIFO: wr/rd pointers of log2(FIFO_DEPTH) bits that wrap naturally. The count is one bit wider.
  - Push and pop on the same edge leave the count unchanged.
  - A push into an empty FIFO is not poppable until the following edge (no bypass).
- Counter: 16 bits. Each line bit is held exactly CLKS_PER_BIT cycles; the counter runs 0..CLKS_PER_BIT-1, then clears.
- FSM states:
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head into the shift register, set o_tx=0, counter=0, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles. Then drive bit 0 and go to DATA.
  - DATA: drive shift[bit_index] for CLKS_PER_BIT cycles. bit_index counts 0..7. After bit 7 completes, drive o_tx=1 and go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the last cycle, pulse o_done=1.
    - If the FIFO is non-empty: pop, drive o_tx=0, go to START. No idle cycle between frames.
    - Otherwise go to IDLE.
  - Illegal/default state: go to IDLE with o_tx=1.
- Latency: byte pushed at edge N. Pop and the start-bit falling edge both occur at edge N+1, so o_tx is low after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are periodic at that interval.
- o_busy = (state != IDLE) || FIFO non-empty, registered alongside state.
- Pushes while transmitting do not disturb the active frame. The shift register is loaded only on pop.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: add state PARITY between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits), held CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT; all other timing is unchanged.
- Undefined: no PARITY state, 8N1 frames of 10*CLKS_PER_BIT.

Test Plan:
- CLKS_PER_BIT=8, push 0xA5 once → o_tx low 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles. o_done pulses on cycle 80 after the falling edge; o_busy clears after it.
- Push 0x00, 0xFF, 0x3C on consecutive cycles → three frames with no idle gap. Falling edges exactly 80 cycles apart; three o_done pulses.
- FIFO_DEPTH=4: push 6 bytes on 6 consecutive cycles with the line idle:
  - The 1st byte is popped on the 2nd cycle, so 5 are accepted.
  - o_ready drops after the 5th push; the 6th is dropped.
  - Exactly 5 frames go out in order.
- Assert i_reset for 1 cycle at cycle 35 of a frame → o_tx high on the next edge; no o_done. The remaining queued bytes are never sent; o_busy=0, o_ready=1.
- Loopback: o_tx wired to the existing receiver (same CLKS_PER_BIT) and bytes 0x00..0xFF sent → the receiver reports all 256 bytes in order, with no framing errors.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1 after data bit 7; send 0x03 → parity bit 0; frame 88 cycles at CLKS_PER_BIT=8.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter, LSB first, with a small input FIFO and gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns / 1ps

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_data_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [15:0]     BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     DonePre  = 16'(CLKS_PER_BIT - 2);
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    StParity = 3'd4
`endif
  } state_e;

  // FIFO storage and pointers
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic [7:0]      head;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Transmit engine
  state_e      state_q;
  logic [15:0] counter_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end;

  assign fifo_empty = (count_q == '0);
  assign o_ready    = (count_q != FifoFull);
  assign push       = i_data_valid && o_ready;
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (counter_q == BitLast);

  // Pop decisions use the registered count, so a fresh push is never popped on the same edge.
  assign pop = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data_byte;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      counter_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b1;
      case (state_q)
        StIdle: begin
          tx_q      <= 1'b1;
          counter_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q <= head;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end else begin
            busy_q <= (count_d != '0);
          end
        end

        StStart: begin
          if (bit_end) begin
            counter_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end

        StData: begin
          if (bit_end) begin
            counter_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= ^shift_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            counter_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= StStop;
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end
`endif

        StStop: begin
          // Registered pulse lands on the final stop-bit cycle.
          done_q <= (counter_q == DonePre);
          if (bit_end) begin
            counter_q <= '0;
            bit_idx_q <= '0;
            if (pop) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
              busy_q  <= (count_d != '0);
            end
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end

        default: begin
          state_q   <= StIdle;
          tx_q      <= 1'b1;
          counter_q <= '0;
          bit_idx_q <= '0;
          busy_q    <= (count_d != '0);
        end
      endcase
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes and checks frames.
`timescale 1ns / 1ps

module tb_uart_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       i_clock;
  logic       i_reset;
  logic       i_data_valid;
  logic [7:0] i_data_byte;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int checks      = 0;
  int failures    = 0;
  int frames_seen = 0;
  int done_pulses = 0;
  int cyc         = 0;

  logic [7:0] exp_q[$];
  int         start_times[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_data_valid(i_data_valid),
    .i_data_byte (i_data_byte),
    .o_ready     (o_ready),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Expected line level at cycle c (0-based) of a frame carrying byte b.
  function automatic logic line_level(input logic [7:0] b, input int c);
    if (c < CPB) return 1'b0;
    if (c < 9 * CPB) return b[c / CPB - 1];
`ifdef UART_TX_PARITY_EN
    if (c < 10 * CPB) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic monitor();
    bit         in_frame = 0;
    int         c        = 0;
    logic [7:0] b        = 8'h00;
    int         bad_bits = 0;
    int         bad_done = 0;
    int         bad_busy = 0;
    forever begin
      @(negedge i_clock);
      cyc++;
      if (i_reset) begin
        in_frame = 0;
        continue;
      end
      if (!in_frame) begin
        if (o_tx === 1'b0) begin
          start_times.push_back(cyc);
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          b        = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          in_frame = 1;
          c        = 0;
          bad_bits = 0;
          bad_done = 0;
          bad_busy = 0;
        end else begin
          check("idle_done", o_done, 0);
        end
      end
      if (in_frame) begin
        if (o_tx !== line_level(b, c)) bad_bits++;
        if (o_done !== (c == FRAME - 1)) bad_done++;
        if (o_busy !== 1'b1) bad_busy++;
        if (o_done === 1'b1) done_pulses++;
        c++;
        if (c == FRAME) begin
          check("frame_bits", bad_bits, 0);
          check("frame_done", bad_done, 0);
          check("frame_busy", bad_busy, 0);
          frames_seen++;
          in_frame = 0;
        end
      end
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_seen < n && k < budget) begin
      tick();
      k++;
    end
    check("frames_done", frames_seen, n);
  endtask

  logic [7:0] t2_bytes [3] = '{8'h00, 8'hFF, 8'h3C};
  logic [7:0] t3_bytes [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
  logic       t3_acc   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int base;
    int sbase;
    int dbase;
    int k;

    i_reset      = 1'b1;
    i_data_valid = 1'b0;
    i_data_byte  = 8'h00;
    repeat (3) tick();
    check("reset_tx", o_tx, 1);
    check("reset_busy", o_busy, 0);
    check("reset_ready", o_ready, 1);
    check("reset_done", o_done, 0);
    i_reset = 1'b0;
    tick();

    fork
      monitor();
    join_none

    // Single byte: latency, no bypass, busy clearing
    base  = frames_seen;
    dbase = done_pulses;
    i_data_valid = 1'b1;
    i_data_byte  = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    i_data_valid = 1'b0;
    check("no_bypass", o_tx, 1);
    check("busy_after_push", o_busy, 1);
    tick();
    check("start_latency", o_tx, 0);
    wait_frames(base + 1, FRAME + 20);
    check("busy_clear", o_busy, 0);
    check("ready_idle", o_ready, 1);
    check("done_count_1", done_pulses - dbase, 1);

    // Back-to-back frames
    base  = frames_seen;
    dbase = done_pulses;
    sbase = start_times.size();
    for (int i = 0; i < 3; i++) begin
      i_data_valid = 1'b1;
      i_data_byte  = t2_bytes[i];
      exp_q.push_back(t2_bytes[i]);
      tick();
    end
    i_data_valid = 1'b0;
    wait_frames(base + 3, 3 * FRAME + 20);
    check("gap_1_2", start_times[sbase + 1] - start_times[sbase], FRAME);
    check("gap_2_3", start_times[sbase + 2] - start_times[sbase + 1], FRAME);
    check("done_count_3", done_pulses - dbase, 3);
    check("busy_clear_b2b", o_busy, 0);

    // FIFO overflow: six pushes, fifth fills the FIFO, sixth dropped
    base = frames_seen;
    for (int i = 0; i < 6; i++) begin
      check("ready_before_push", o_ready, 32'(t3_acc[i]));
      i_data_valid = 1'b1;
      i_data_byte  = t3_bytes[i];
      if (t3_acc[i]) exp_q.push_back(t3_bytes[i]);
      tick();
    end
    i_data_valid = 1'b0;
    wait_frames(base + 5, 5 * FRAME + 20);
    repeat (2 * FRAME) tick();
    check("no_extra_frame", frames_seen, base + 5);
    check("exp_drained_fifo", exp_q.size(), 0);
    check("ready_after_fifo", o_ready, 1);

    // Reset mid-frame discards the frame and the queue
    sbase = start_times.size();
    for (int i = 0; i < 3; i++) begin
      i_data_valid = 1'b1;
      i_data_byte  = 8'h11 * 8'(i + 1);
      exp_q.push_back(8'h11 * 8'(i + 1));
      tick();
    end
    i_data_valid = 1'b0;
    k = 0;
    while (start_times.size() == sbase && k < 50) begin
      tick();
      k++;
    end
    check("reset_test_start", start_times.size(), sbase + 1);
    repeat (33) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("abort_tx", o_tx, 1);
    check("abort_busy", o_busy, 0);
    check("abort_ready", o_ready, 1);
    check("abort_done", o_done, 0);
    exp_q.delete();
    base = frames_seen;
    repeat (3 * FRAME) tick();
    check("abort_no_frames", frames_seen, base);
    check("abort_no_starts", start_times.size(), sbase + 1);
    check("abort_busy_later", o_busy, 0);

`ifdef UART_TX_PARITY_EN
    // Parity bit values and 11-bit frame length
    base  = frames_seen;
    sbase = start_times.size();
    i_data_valid = 1'b1;
    i_data_byte  = 8'h07;
    exp_q.push_back(8'h07);
    tick();
    i_data_byte = 8'h03;
    exp_q.push_back(8'h03);
    tick();
    i_data_valid = 1'b0;
    wait_frames(base + 2, 2 * FRAME + 20);
    check("parity_frame_len", start_times[sbase + 1] - start_times[sbase], FRAME);
`endif

    // Full byte sweep through the line decoder
    base = frames_seen;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      while (!o_ready && k < 2 * FRAME) begin
        tick();
        k++;
      end
      check("sweep_ready", o_ready, 1);
      i_data_valid = 1'b1;
      i_data_byte  = 8'(i);
      exp_q.push_back(8'(i));
      tick();
      i_data_valid = 1'b0;
    end
    wait_frames(base + 256, 256 * FRAME + 200);
    check("sweep_drained", exp_q.size(), 0);
    tick();
    check("sweep_busy_clear", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
